mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/mem_access_if.sv | 21 ++
 rtl/lsu_load_format.sv | 37 +++
 rtl/mem_access.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load/store unit state encoding and funct3 access-size codes.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-stage access unit (master) and the data memory (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_load_format.sv
// Load formatter: picks the addressed byte/halfword lane of the read word and extends it.
module lsu_load_format
  import pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane selection followed by sign or zero extension.
  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    data   = 32'h0000_0000;
    case (addr_lo)
      2'b00:   lane_b = rdata[7:0];
      2'b01:   lane_b = rdata[15:8];
      2'b10:   lane_b = rdata[23:16];
      2'b11:   lane_b = rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h00_0000, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0000, lane_h};
      F3_W:    data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: one outstanding data-memory request, store lane formatting,
// load result capture while the MEM/WB register is stalled, and flush draining.
module mem_access
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  input  logic        stall_in,
  input  logic        flush_M,
  output logic [31:0] rd_data_M,
  output logic        stall_mem,
  output logic        mem_err_M,
  mem_access_if.master dmem
);

  lsu_state_t  state_q, state_d;
  logic [31:0] cap_q, cap_d;
  logic        flushed_q, flushed_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        is_load_q, is_load_d;

  logic        pending, misaligned, illegal, err, legal;
  logic        req;
  logic [31:0] fmt_data, load_val;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << lo;
      F3_H, F3_HU: be = 4'b0011 << lo;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Reset gates the pending term so nothing escapes onto the bus while rst is held.
  assign pending = (mem_rd_M | mem_wr_M) & ~flush_M & ~rst;

  // Alignment check against the access size.
  always_comb begin
    misaligned = 1'b0;
    case (funct3_M)
      F3_H, F3_HU: misaligned = alu_o_M[0];
      F3_W:        misaligned = (alu_o_M[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  assign illegal  = ~f3_legal(funct3_M, mem_wr_M) | (mem_rd_M & mem_wr_M) | misaligned;
  assign err      = pending & illegal;
  assign legal    = pending & ~illegal;
  assign load_val = is_load_q ? fmt_data : 32'h0000_0000;

  lsu_load_format u_fmt (
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .rdata   (dmem.dmem_rdata),
    .data    (fmt_data)
  );

  // Next-state, request latching and pipeline-side outputs.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    flushed_d = flushed_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    is_load_d = is_load_q;
    req       = 1'b0;
    rd_data_M = 32'h0000_0000;
    stall_mem = 1'b0;
    mem_err_M = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_err_M = err;
        stall_mem = legal;
        if (legal) begin
          req       = 1'b1;
          we_d      = mem_wr_M;
          addr_d    = {alu_o_M[31:2], 2'b00};
          be_d      = be_of(funct3_M, alu_o_M[1:0]);
          wdata_d   = mem_wr_M ? wdata_of(funct3_M, wr_data_M) : 32'h0000_0000;
          ld_f3_d   = funct3_M;
          ld_lo_d   = alu_o_M[1:0];
          is_load_d = mem_rd_M;
          flushed_d = 1'b0;
          state_d   = dmem.dmem_gnt ? ST_WAIT : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A flushed request still has to be granted; its response is then drained.
        req       = 1'b1;
        stall_mem = pending;
        flushed_d = flushed_q | flush_M;
        if (dmem.dmem_gnt) begin
          state_d = (flushed_q | flush_M) ? ST_DRAIN : ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          if (flush_M) begin
            state_d = ST_IDLE;
          end else begin
            rd_data_M = load_val;
            if (stall_in) begin
              cap_d   = load_val;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          stall_mem = pending;
          state_d   = flush_M ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_HOLD: begin
        rd_data_M = flush_M ? 32'h0000_0000 : cap_q;
        state_d   = (flush_M | ~stall_in) ? ST_IDLE : ST_HOLD;
      end
      ST_DRAIN: begin
        mem_err_M = err;
        stall_mem = legal;
        state_d   = dmem.dmem_rvalid ? ST_IDLE : ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & we_d;
  assign dmem.dmem_addr  = req ? addr_d : 32'h0000_0000;
  assign dmem.dmem_be    = req ? be_d : 4'b0000;
  assign dmem.dmem_wdata = req ? wdata_d : 32'h0000_0000;

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cap_q     <= 32'h0000_0000;
      flushed_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      ld_f3_q   <= 3'b000;
      ld_lo_q   <= 2'b00;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      flushed_q <= flushed_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
      is_load_q <= is_load_d;
    end
  end

endmodule
